// File: rtl/wait_memory.sv
// Byte-wide memory with a wait-state generator that stalls the MPU via RDY,
// plus write protection for the top region and a completed-access counter.
module wait_memory #(
    parameter int          MEM_DEPTH = 16,
    parameter int          WAIT_RD   = 1,
    parameter int          WAIT_WR   = 0,
    parameter logic [15:0] ROM_BASE  = 16'hf000
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic [15:0] A,
    input  logic        R_W,
    input  logic [7:0]  WD,
    output logic [7:0]  RD,
    output logic        RDY,
    output logic        PROT_ERR,
    output logic [15:0] ACC_CNT
);

    localparam logic [3:0] NEED_RD = 4'(WAIT_RD);
    localparam logic [3:0] NEED_WR = 4'(WAIT_WR);

    logic [7:0]           ram [0:(2**MEM_DEPTH)-1];

    logic [3:0]           r_cnt;
    logic                 r_prot_err;
    logic [15:0]          r_acc_cnt;

    logic [3:0]           w_need;
    logic                 w_rdy;
    logic                 w_prot;
    logic                 w_wr_en;
    logic [MEM_DEPTH-1:0] w_idx;

    // NEED is re-evaluated every cycle, so a mid-wait change of R_W simply
    // moves the completion point instead of locking the counter.
    assign w_need  = R_W ? NEED_RD : NEED_WR;
    assign w_rdy   = (r_cnt >= w_need);
    assign w_prot  = (A >= ROM_BASE);
    assign w_idx   = A[MEM_DEPTH-1:0];
    assign w_wr_en = w_rdy && !R_W && !w_prot && !RES;

    assign RD       = ram[w_idx];
    assign RDY      = w_rdy;
    assign PROT_ERR = r_prot_err;
    assign ACC_CNT  = r_acc_cnt;

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            r_cnt      <= 4'd0;
            r_prot_err <= 1'b0;
            r_acc_cnt  <= 16'd0;
        end else if (w_rdy) begin
            r_cnt     <= 4'd0;
            r_acc_cnt <= r_acc_cnt + 16'd1;
            if (!R_W && w_prot) begin
                r_prot_err <= 1'b1;
            end
        end else begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    // Storage has no reset so contents survive RES; writes are still blocked while it is high.
    always_ff @(posedge CLK) begin
        if (w_wr_en) begin
            ram[w_idx] <= WD;
        end
    end

endmodule

// File: tb/tb_wait_memory.sv
// Scoreboard bench for wait_memory: two instances cover read-stall/protection/wrap
// and write-stall/aliasing/mid-wait-reset behaviour.
module tb_wait_memory;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        res_a, r_w_a, rdy_a, prot_a;
    logic [15:0] a_a, acc_a;
    logic [7:0]  wd_a, rd_a;
    logic        res_b, r_w_b, rdy_b, prot_b;
    logic [15:0] a_b, acc_b;
    logic [7:0]  wd_b, rd_b;

    wait_memory #(.MEM_DEPTH(16), .WAIT_RD(2), .WAIT_WR(0), .ROM_BASE(16'hf000)) dut_a (
        .CLK(clk), .RES(res_a), .A(a_a), .R_W(r_w_a), .WD(wd_a),
        .RD(rd_a), .RDY(rdy_a), .PROT_ERR(prot_a), .ACC_CNT(acc_a)
    );

    wait_memory #(.MEM_DEPTH(12), .WAIT_RD(0), .WAIT_WR(3), .ROM_BASE(16'hf000)) dut_b (
        .CLK(clk), .RES(res_b), .A(a_b), .R_W(r_w_b), .WD(wd_b),
        .RD(rd_b), .RDY(rdy_b), .PROT_ERR(prot_b), .ACC_CNT(acc_b)
    );

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q_a [$];
    logic [7:0] exp_q_b [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Monitor: a read completes when RDY is high with R_W=1; compare RD with the queued value.
    always @(negedge clk) begin
        logic [7:0] e;
        if (rdy_a && r_w_a && exp_q_a.size() > 0) begin
            e = exp_q_a.pop_front();
            chk("a_read_data", {24'd0, rd_a}, {24'd0, e});
        end
        if (rdy_b && r_w_b && exp_q_b.size() > 0) begin
            e = exp_q_b.pop_front();
            chk("b_read_data", {24'd0, rd_b}, {24'd0, e});
        end
    end

    // One bus access, started just after a rising edge; returns just after its completing edge.
    task automatic acc(input bit sel, input logic [15:0] addr, input logic rw,
                       input logic [7:0] wd, input logic [7:0] exp_rd,
                       input int exp_stall, input string nm);
        int  stalls;
        bit  done;
        stalls = 0;
        done   = 1'b0;
        if (sel) begin
            a_b = addr; r_w_b = rw; wd_b = wd;
            if (rw) exp_q_b.push_back(exp_rd);
        end else begin
            a_a = addr; r_w_a = rw; wd_a = wd;
            if (rw) exp_q_a.push_back(exp_rd);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sel ? rdy_b : rdy_a) begin
                done = 1'b1;
                break;
            end
            stalls++;
        end
        if (!done) chk({nm, "_timeout"}, 32'd0, 32'd1);
        else       chk({nm, "_stalls"}, stalls, exp_stall);
        @(posedge clk);
        #1;
    endtask

    initial begin
        res_a = 1'b1; a_a = 16'h0200; r_w_a = 1'b1; wd_a = 8'h00;
        res_b = 1'b1; a_b = 16'h0000; r_w_b = 1'b0; wd_b = 8'h00;
        dut_a.ram[16'h0200] = 8'h5a;
        dut_a.ram[16'h0010] = 8'h11;
        dut_a.ram[16'hfffc] = 8'h00;
        dut_a.ram[16'hf000] = 8'h00;
        dut_b.ram[12'h300]  = 8'h12;

        #2;
        chk("a_rst_rdy_read", {31'd0, rdy_a}, 32'd0);
        chk("a_rst_acc", {16'd0, acc_a}, 32'd0);
        chk("a_rst_prot", {31'd0, prot_a}, 32'd0);
        chk("b_rst_rdy_write", {31'd0, rdy_b}, 32'd0);
        chk("b_rst_acc", {16'd0, acc_b}, 32'd0);

        // Instance B: write stalls, aliasing, reset abandoning a pending write.
        @(posedge clk); #1;
        res_b = 1'b0;
        acc(1'b1, 16'h1234, 1'b0, 8'ha5, 8'h00, 3, "b_wr_1234");
        chk("b_acc_after_wr", {16'd0, acc_b}, 32'd1);
        chk("b_ram_alias", {24'd0, dut_b.ram[12'h234]}, 32'h0000_00a5);
        acc(1'b1, 16'h0234, 1'b1, 8'h00, 8'ha5, 0, "b_rd_0234");
        chk("b_acc_after_rd", {16'd0, acc_b}, 32'd2);

        a_b = 16'h0300; r_w_b = 1'b0; wd_b = 8'h77;
        @(negedge clk); chk("b_wait_rdy0", {31'd0, rdy_b}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk); chk("b_wait_rdy1", {31'd0, rdy_b}, 32'd0);
        @(posedge clk); #1;
        res_b = 1'b1;
        #1;
        chk("b_midrst_cnt", {28'd0, dut_b.r_cnt}, 32'd0);
        chk("b_midrst_acc", {16'd0, acc_b}, 32'd0);
        chk("b_midrst_rdy", {31'd0, rdy_b}, 32'd0);
        @(posedge clk); #1;
        chk("b_midrst_ram", {24'd0, dut_b.ram[12'h300]}, 32'h0000_0012);
        res_b = 1'b0;
        acc(1'b1, 16'h0300, 1'b0, 8'h77, 8'h00, 3, "b_wr_after_rst");
        chk("b_ram_after_rst", {24'd0, dut_b.ram[12'h300]}, 32'h0000_0077);
        chk("b_acc_after_rst", {16'd0, acc_b}, 32'd1);
        acc(1'b1, 16'h0300, 1'b1, 8'h00, 8'h77, 0, "b_rd_0300");
        res_b = 1'b1;

        // Instance A: read stalls, write-after-read, protection and its boundary.
        res_a = 1'b0;
        acc(1'b0, 16'h0200, 1'b1, 8'h00, 8'h5a, 2, "a_rd_0200");
        chk("a_acc_1", {16'd0, acc_a}, 32'd1);
        acc(1'b0, 16'h0010, 1'b1, 8'h00, 8'h11, 2, "a_rd_0010_old");
        acc(1'b0, 16'h0010, 1'b0, 8'hc3, 8'h00, 0, "a_wr_0010");
        chk("a_rd_new_after_edge", {24'd0, rd_a}, 32'h0000_00c3);
        chk("a_ram_0010", {24'd0, dut_a.ram[16'h0010]}, 32'h0000_00c3);
        chk("a_prot_clear", {31'd0, prot_a}, 32'd0);
        chk("a_acc_3", {16'd0, acc_a}, 32'd3);
        acc(1'b0, 16'h0010, 1'b1, 8'h00, 8'hc3, 2, "a_rd_0010_new");
        acc(1'b0, 16'hfffc, 1'b0, 8'hff, 8'h00, 0, "a_wr_fffc");
        chk("a_ram_fffc", {24'd0, dut_a.ram[16'hfffc]}, 32'd0);
        chk("a_prot_set", {31'd0, prot_a}, 32'd1);
        chk("a_acc_5", {16'd0, acc_a}, 32'd5);
        acc(1'b0, 16'hfffc, 1'b1, 8'h00, 8'h00, 2, "a_rd_fffc");
        chk("a_prot_sticky", {31'd0, prot_a}, 32'd1);
        acc(1'b0, 16'hefff, 1'b0, 8'h3c, 8'h00, 0, "a_wr_efff");
        acc(1'b0, 16'hefff, 1'b1, 8'h00, 8'h3c, 2, "a_rd_efff");
        acc(1'b0, 16'hf000, 1'b0, 8'h99, 8'h00, 0, "a_wr_f000");
        acc(1'b0, 16'hf000, 1'b1, 8'h00, 8'h00, 2, "a_rd_f000");
        chk("a_acc_10", {16'd0, acc_a}, 32'd10);

        // Read switched to a write mid-wait: NEED drops to 0 and the write completes.
        a_a = 16'h0200; r_w_a = 1'b1;
        @(negedge clk); chk("a_switch_rdy0", {31'd0, rdy_a}, 32'd0);
        @(posedge clk); #1;
        a_a = 16'h0400; r_w_a = 1'b0; wd_a = 8'h44;
        #1;
        chk("a_switch_rdy1", {31'd0, rdy_a}, 32'd1);
        @(posedge clk); #1;
        chk("a_acc_11", {16'd0, acc_a}, 32'd11);
        acc(1'b0, 16'h0400, 1'b1, 8'h00, 8'h44, 2, "a_rd_0400");

        // Reset clears flags but not memory, then 65537 zero-wait writes wrap ACC_CNT.
        res_a = 1'b1;
        #1;
        chk("a_rst2_prot", {31'd0, prot_a}, 32'd0);
        chk("a_rst2_acc", {16'd0, acc_a}, 32'd0);
        chk("a_rst2_ram", {24'd0, dut_a.ram[16'h0010]}, 32'h0000_00c3);
        @(posedge clk); #1;
        a_a = 16'h0020; r_w_a = 1'b0; wd_a = 8'h00;
        res_a = 1'b0;
        repeat (65535) @(posedge clk);
        #1;
        chk("a_acc_ffff", {16'd0, acc_a}, 32'h0000_ffff);
        @(posedge clk); #1;
        chk("a_acc_wrap0", {16'd0, acc_a}, 32'h0000_0000);
        @(posedge clk); #1;
        chk("a_acc_wrap1", {16'd0, acc_a}, 32'h0000_0001);
        chk("a_rdy_need0", {31'd0, rdy_a}, 32'd1);

        @(negedge clk);
        chk("a_queue_drained", exp_q_a.size(), 32'd0);
        chk("b_queue_drained", exp_q_b.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wait_memory.md
WAIT_MEMORY -- requirements
Module: wait_memory

Interface
REQ-001 SHALL provide parameter MEM_DEPTH, default 16, meaning the number of implemented address bits (array of 2**MEM_DEPTH bytes).
REQ-002 SHALL provide parameter WAIT_RD, default 1, meaning stall cycles inserted per read (legal 0..15).
REQ-003 SHALL provide parameter WAIT_WR, default 0, meaning stall cycles inserted per write (legal 0..15).
REQ-004 SHALL provide parameter ROM_BASE, default 16'hf000, meaning the lowest write-protected bus address; protection covers ROM_BASE..16'hffff.
REQ-005 CLK  input  1  single clock; all state updates on rising edge.
REQ-006 RES  input  1  reset, asynchronous, active-high.
REQ-007 A  input  16  bus address from MPU (ABH:ABL).
REQ-008 R_W  input  1  1 = read, 0 = write.
REQ-009 WD  input  8  write data from MPU.
REQ-010 RD  output  8  read data to MPU.
REQ-011 RDY  output  1  1 = current access completes at next rising CLK edge; 0 = MPU holds A/R_W/WD.
REQ-012 PROT_ERR  output  1  sticky flag: a write to the protected region has completed.
REQ-013 ACC_CNT  output  16  count of completed accesses.
REQ-014 Storage SHALL be an 8-bit array named ram, indexed by A[MEM_DEPTH-1:0], so the bench can preload it hierarchically.

Function
REQ-015 Address bits above MEM_DEPTH-1 SHALL be ignored for storage (aliasing); protection decode SHALL use the full 16-bit A.
REQ-016 Wait counter CNT (4 bits) SHALL define NEED = R_W ? WAIT_RD : WAIT_WR; RDY SHALL be combinational: RDY = (CNT >= NEED).
REQ-017 On rising CLK with RDY=1: access completes and CNT SHALL load 0; with RDY=0: CNT SHALL increment by 1.
REQ-018 Two-state behaviour: READY (CNT>=NEED) and WAIT (CNT<NEED); an access SHALL spend exactly NEED cycles with RDY=0, then one cycle with RDY=1.
REQ-019 With NEED=0, RDY SHALL stay 1 continuously and every cycle SHALL be a complete access.
REQ-020 RD SHALL be combinational ram[A[MEM_DEPTH-1:0]] at all times, independent of R_W and RDY.
REQ-021 A write SHALL update ram only on the completing edge (RDY=1, R_W=0) and only when A < ROM_BASE.
REQ-022 A completing write with A >= ROM_BASE SHALL leave ram unchanged and set PROT_ERR to 1 on that edge; PROT_ERR SHALL stay 1 until reset.
REQ-023 ACC_CNT SHALL increment by 1 on every completing edge (read or write, protected or not), wrapping 16'hffff -> 16'h0000.
REQ-024 A write-after-read to the same address in consecutive completing cycles SHALL return old data on RD before the write edge and new data after it.
REQ-025 Changes to A/R_W while RDY=0 are an MPU protocol violation; the block SHALL still re-evaluate NEED each cycle with no lockup.

Reset
REQ-026 While RES=1: CNT=0, PROT_ERR=0, ACC_CNT=0, no write SHALL occur; RDY reflects CNT=0 (1 only if NEED=0).
REQ-027 RES asserted mid-wait SHALL immediately abandon the access; a pending write SHALL NOT be performed.
REQ-028 Reset SHALL NOT modify ram contents.
REQ-029 After RES falls, the first access SHALL start with CNT=0 and observe the full NEED stalls.

Verification
REQ-030 WAIT_RD=2, preload ram[16'h0200]=8'h5a, read A=16'h0200 -> RDY 0,0,1; RD=8'h5a; ACC_CNT=1 after completing edge.
REQ-031 WAIT_WR=0, write 8'hc3 to 16'h0010 -> RDY stays 1; ram[16'h0010]=8'hc3 next cycle; PROT_ERR=0.
REQ-032 ROM_BASE=16'hf000, preload ram[16'hfffc]=8'h00, write 8'hff to 16'hfffc -> ram[16'hfffc] stays 8'h00; PROT_ERR=1 until RES.
REQ-033 WAIT_WR=3, write 8'h77 to 16'h0300, assert RES after 2 stall cycles -> ram[16'h0300] unchanged; CNT=0, ACC_CNT=0.
REQ-034 MEM_DEPTH=12, write 8'ha5 to 16'h1234 -> read 16'h0234 returns 8'ha5 (aliasing).
REQ-035 Drive 65537 zero-wait completing accesses from reset -> ACC_CNT=16'h0001 (wrap verified).
